matmul_arbiter: RTL and testbench
=================================

Name: matmul_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 2x2 8-bit matrix-multiply unit between two requesters (e.g. pipeline core and DMA/test port).
- Accepts operand pairs over valid/ready, issues a one-cycle start to the multiplier, waits for its done, and returns C to the winning requester over a held response handshake.
- A watchdog returns an error response if the unit never signals done.

Parameters:
- TIMEOUT_CYCLES, 16: max cycles in WAIT before abort; legal 2..255.
- CAPTURE_DELAY, 0: extra cycles between sampling mm_done=1 and capturing mm_c; legal 0..3.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- req0_valid  in  1  requester 0 has operands
- req0_ready  out  1  requester 0 operands accepted this cycle
- req0_a  in  32  requester 0 matrix A, packed {a11,a10,a01,a00}
- req0_b  in  32  requester 0 matrix B, same packing
- rsp0_valid  out  1  result for requester 0
- rsp0_ready  in  1  requester 0 takes result
- rsp0_c  out  32  result matrix C
- rsp0_err  out  1  timeout flag accompanying rsp0_valid
- req1_valid, req1_ready, req1_a, req1_b, rsp1_valid, rsp1_ready, rsp1_c, rsp1_err: same as above for requester 1
- mm_start  out  1  one-cycle start to multiplier (its is_matrix_mult input)
- mm_a  out  32  operand A to multiplier, registered
- mm_b  out  32  operand B to multiplier, registered
- mm_c  in  32  multiplier result
- mm_done  in  1  multiplier completion flag
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0; rr_ptr=0 (requester 0 has priority first); counters cleared. Reset mid-operation aborts immediately and discards any pending response; the multiplier is not notified.
- FSM states: IDLE, ISSUE, WAIT, SETTLE, RESP.
- IDLE:
  - Grant is combinational. If both valid, the requester selected by rr_ptr wins; otherwise the single valid requester wins.
  - reqN_ready=1 only for the winner, in the same cycle.
  - On acceptance: latch a/b into mm_a/mm_b, record grant id, flip rr_ptr to the loser, go to ISSUE.
  - req*_ready is 0 in every other state.
- ISSUE: mm_start=1 for exactly this one cycle; clear timeout counter; go to WAIT.
- WAIT:
  - mm_start=0. Count cycles.
  - mm_done=1 -> SETTLE if CAPTURE_DELAY>0, otherwise capture mm_c into rspN_c with err=0 and go to RESP.
  - If the count reaches TIMEOUT_CYCLES without done: rspN_c=0, err=1, go to RESP.
  - If done and timeout occur in the same cycle, done wins.
- SETTLE: wait CAPTURE_DELAY cycles, then capture mm_c with err=0 and go to RESP.
- RESP:
  - rspN_valid=1 only for the granted requester, with rspN_c/rspN_err stable while valid.
  - On rspN_ready=1: drop valid next cycle and return to IDLE.
  - No new request is accepted in the release cycle; earliest new acceptance is the following cycle.
- Latency, valid-accept to rsp_valid, with the multiplier done 1 cycle after start: accept(IDLE) -> ISSUE -> WAIT(done=0) -> WAIT(done=1) -> RESP, so rsp_valid rises 4 cycles after the accept edge when CAPTURE_DELAY=0.
- Operand registers: mm_a/mm_b hold their value until the next acceptance.
- Fairness: rr_ptr changes only on acceptance. A requester that keeps valid high is served within at most one other transaction.

Optional Feature:
- MATMUL_ARB_STATS_EN defined:
  - Adds outputs stat_grant0 [15:0], stat_grant1 [15:0], stat_timeout [7:0].
  - Grant counters increment on acceptance for that requester; stat_timeout increments on each timeout.
  - All counters saturate at all-ones and clear on rst.
- Not defined: these ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Single request, req0 A=0x04030201, B=0x08070605, unit done 1 cycle after start -> mm_start pulses once, rsp0_valid 4 cycles after accept, rsp0_c = mm_c sampled with done=1, rsp0_err=0.
- Both valid simultaneously from reset -> req0 granted first, req1 second; repeat with both held high for 4 transactions -> grants alternate 0,1,0,1.
- mm_done stuck 0, TIMEOUT_CYCLES=16 -> rsp_valid with err=1, c=0, exactly 16 WAIT cycles; next request is served normally.
- rsp0_ready held low 10 cycles -> rsp0_valid/c stable; req1_ready=0 throughout; req1 accepted the cycle after release+1.
- rst asserted during WAIT -> all outputs 0 immediately (async); after deassert a new req1 goes through, rr_ptr = 0.
- With MATMUL_ARB_STATS_EN: 3 grants to req0, 1 to req1, 1 timeout -> stat_grant0=3, stat_grant1=1, stat_timeout=1.

Source files
------------

// File: rtl/matmul_arbiter.sv
// Round-robin arbiter/sequencer sharing one 2x2 8-bit matrix-multiply unit between two requesters.
// Optional statistics counters are built when MATMUL_ARB_STATS_EN is defined.
module matmul_arbiter #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CAPTURE_DELAY  = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [31:0] rsp0_c,
    output logic        rsp0_err,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp1_c,
    output logic        rsp1_err,
    output logic        mm_start,
    output logic [31:0] mm_a,
    output logic [31:0] mm_b,
    input  logic [31:0] mm_c,
    input  logic        mm_done,
    output logic        busy,
`ifdef MATMUL_ARB_STATS_EN
    output logic [15:0] stat_grant0,
    output logic [15:0] stat_grant1,
    output logic [7:0]  stat_timeout,
`endif
    output logic [2:0]  fsm_state
);

    // Handshakes: a transfer happens in a cycle where valid and ready are both high;
    // a raised valid keeps its payload stable until that cycle.
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ISSUE  = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_SETTLE = 3'd3;
    localparam logic [2:0] S_RESP   = 3'd4;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0] CD_LAST = 8'((CAPTURE_DELAY > 0) ? (CAPTURE_DELAY - 1) : 0);

    logic [2:0] state;
    logic [7:0] cnt;
    logic       rr_ptr;
    logic       gid;
    logic       win_id;
    logic       accept;

    always_comb begin
        win_id     = 1'b0;
        accept     = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        // With both requesting, rr_ptr names the winner; otherwise the lone requester wins.
        win_id     = (req0_valid && req1_valid) ? rr_ptr : req1_valid;
        if (state == S_IDLE) begin
            accept     = req0_valid | req1_valid;
            req0_ready = req0_valid & ~win_id;
            req1_ready = req1_valid & win_id;
        end
    end

    assign mm_start   = (state == S_ISSUE);
    assign rsp0_valid = (state == S_RESP) && !gid;
    assign rsp1_valid = (state == S_RESP) && gid;
    assign busy       = (state != S_IDLE);
    assign fsm_state  = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= 8'd0;
            rr_ptr   <= 1'b0;
            gid      <= 1'b0;
            mm_a     <= 32'd0;
            mm_b     <= 32'd0;
            rsp0_c   <= 32'd0;
            rsp0_err <= 1'b0;
            rsp1_c   <= 32'd0;
            rsp1_err <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        mm_a   <= win_id ? req1_a : req0_a;
                        mm_b   <= win_id ? req1_b : req0_b;
                        gid    <= win_id;
                        rr_ptr <= ~win_id;
                        state  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    cnt   <= 8'd0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (mm_done) begin
                        if (CAPTURE_DELAY == 0) begin
                            if (gid) begin
                                rsp1_c   <= mm_c;
                                rsp1_err <= 1'b0;
                            end else begin
                                rsp0_c   <= mm_c;
                                rsp0_err <= 1'b0;
                            end
                            state <= S_RESP;
                        end else begin
                            cnt   <= 8'd0;
                            state <= S_SETTLE;
                        end
                    end else if (cnt == TO_LAST) begin
                        // Unit never answered: return an error with a zero result.
                        if (gid) begin
                            rsp1_c   <= 32'd0;
                            rsp1_err <= 1'b1;
                        end else begin
                            rsp0_c   <= 32'd0;
                            rsp0_err <= 1'b1;
                        end
                        state <= S_RESP;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_SETTLE: begin
                    if (cnt == CD_LAST) begin
                        if (gid) begin
                            rsp1_c   <= mm_c;
                            rsp1_err <= 1'b0;
                        end else begin
                            rsp0_c   <= mm_c;
                            rsp0_err <= 1'b0;
                        end
                        state <= S_RESP;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_RESP: begin
                    if (gid ? rsp1_ready : rsp0_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef MATMUL_ARB_STATS_EN
    // Saturating counters: grants per requester and watchdog expiries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_grant0  <= 16'd0;
            stat_grant1  <= 16'd0;
            stat_timeout <= 8'd0;
        end else begin
            if (accept && !win_id && stat_grant0 != 16'hFFFF) stat_grant0 <= stat_grant0 + 16'd1;
            if (accept && win_id && stat_grant1 != 16'hFFFF) stat_grant1 <= stat_grant1 + 16'd1;
            if (state == S_WAIT && !mm_done && cnt == TO_LAST && stat_timeout != 8'hFF)
                stat_timeout <= stat_timeout + 8'd1;
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_matmul_arbiter.sv
// Bench for matmul_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_matmul_arbiter;
    localparam int TB_TO = 16;
    localparam int TB_CD = 0;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic        rsp0_ready = 1'b1, rsp1_ready = 1'b1;
    logic [31:0] mm_c = '0;
    logic        mm_done = 1'b0;
    logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
    logic [31:0] rsp0_c, rsp1_c, mm_a, mm_b;
    logic        mm_start, busy;
    logic [2:0]  fsm_state;
`ifdef MATMUL_ARB_STATS_EN
    logic [15:0] stat_grant0, stat_grant1;
    logic [7:0]  stat_timeout;
`endif

    matmul_arbiter #(.TIMEOUT_CYCLES(TB_TO), .CAPTURE_DELAY(TB_CD)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_c(rsp0_c), .rsp0_err(rsp0_err),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_c(rsp1_c), .rsp1_err(rsp1_err),
        .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b), .mm_c(mm_c), .mm_done(mm_done),
        .busy(busy),
`ifdef MATMUL_ARB_STATS_EN
        .stat_grant0(stat_grant0), .stat_grant1(stat_grant1), .stat_timeout(stat_timeout),
`endif
        .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference 2x2 product, elements packed {x11,x10,x01,x00}, 8-bit wrap-around.
    function automatic logic [31:0] matmul(input logic [31:0] a, input logic [31:0] b);
        logic [7:0] c00, c01, c10, c11;
        c00 = a[7:0]   * b[7:0]  + a[15:8]  * b[23:16];
        c01 = a[7:0]   * b[15:8] + a[15:8]  * b[31:24];
        c10 = a[23:16] * b[7:0]  + a[31:24] * b[23:16];
        c11 = a[23:16] * b[15:8] + a[31:24] * b[31:24];
        return {c11, c10, c01, c00};
    endfunction

    // Mock multiplier: done pulses mock latency cycles after start (0 = never), C held afterwards.
    int mock_fixed = 2;
    int mock_cnt   = -1;
    int mock_lat;
    always @(posedge clk) begin
        #1;
        mm_done = 1'b0;
        if (rst) begin
            mock_cnt = -1;
        end else if (mm_start) begin
            mock_lat = (mock_fixed >= 0) ? mock_fixed :
                       (($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, TB_TO + 2)));
            mock_cnt = (mock_lat == 0) ? -1 : mock_lat;
            mm_c = $urandom;
        end else if (mock_cnt > 0) begin
            mock_cnt--;
            if (mock_cnt == 0) begin
                mm_done = 1'b1;
                mm_c = matmul(mm_a, mm_b);
            end else begin
                mm_c = $urandom;
            end
        end else if (mock_cnt < 0) begin
            mm_c = $urandom;
        end
    end

    // Transaction-level model: one job in flight, aged in cycles since acceptance.
    logic        m_busy = 1'b0, m_resp = 1'b0, m_err = 1'b0, m_rr = 1'b0, m_gid = 1'b0;
    logic [31:0] m_a = '0, m_b = '0, m_c = '0;
    int          m_age = 0, m_settle = 0, m_g0 = 0, m_g1 = 0, m_to = 0;
    logic        e_r0, e_r1, w;

    always @(negedge clk) begin
        if (rst) begin
            chk1("rst_busy", busy, 1'b0);
            chk1("rst_req0_ready", req0_ready, 1'b0);
            chk1("rst_req1_ready", req1_ready, 1'b0);
            chk1("rst_rsp0_valid", rsp0_valid, 1'b0);
            chk1("rst_rsp1_valid", rsp1_valid, 1'b0);
            chk1("rst_mm_start", mm_start, 1'b0);
            chk32("rst_mm_a", mm_a, 32'd0);
            chk32("rst_mm_b", mm_b, 32'd0);
            chk32("rst_rsp0_c", rsp0_c, 32'd0);
            chk32("rst_rsp1_c", rsp1_c, 32'd0);
            chk1("rst_rsp0_err", rsp0_err, 1'b0);
            chk1("rst_rsp1_err", rsp1_err, 1'b0);
            chk32("rst_state", 32'(fsm_state), 32'd0);
            m_busy = 0; m_resp = 0; m_err = 0; m_rr = 0; m_gid = 0;
            m_a = '0; m_b = '0; m_c = '0; m_age = 0; m_settle = 0;
            m_g0 = 0; m_g1 = 0; m_to = 0;
        end else begin
            e_r0 = !m_busy && req0_valid && !(req1_valid && m_rr);
            e_r1 = !m_busy && req1_valid && !(req0_valid && !m_rr);
            chk1("busy", busy, m_busy);
            chk1("req0_ready", req0_ready, e_r0);
            chk1("req1_ready", req1_ready, e_r1);
            chk1("mm_start", mm_start, m_busy && !m_resp && m_settle == 0 && m_age == 0);
            chk32("mm_a", mm_a, m_a);
            chk32("mm_b", mm_b, m_b);
            chk1("rsp0_valid", rsp0_valid, m_busy && m_resp && !m_gid);
            chk1("rsp1_valid", rsp1_valid, m_busy && m_resp && m_gid);
            if (m_busy && m_resp && !m_gid) begin
                chk32("rsp0_c", rsp0_c, m_c);
                chk1("rsp0_err", rsp0_err, m_err);
            end
            if (m_busy && m_resp && m_gid) begin
                chk32("rsp1_c", rsp1_c, m_c);
                chk1("rsp1_err", rsp1_err, m_err);
            end
`ifdef MATMUL_ARB_STATS_EN
            chk32("stat_grant0", 32'(stat_grant0), 32'(m_g0));
            chk32("stat_grant1", 32'(stat_grant1), 32'(m_g1));
            chk32("stat_timeout", 32'(stat_timeout), 32'(m_to));
`endif
            if (!m_busy) begin
                if (req0_valid || req1_valid) begin
                    w = (req0_valid && req1_valid) ? m_rr : req1_valid;
                    m_busy = 1; m_resp = 0; m_age = 0; m_settle = 0;
                    m_gid = w; m_rr = !w;
                    m_a = w ? req1_a : req0_a;
                    m_b = w ? req1_b : req0_b;
                    if (w) m_g1 = (m_g1 < 65535) ? m_g1 + 1 : m_g1;
                    else   m_g0 = (m_g0 < 65535) ? m_g0 + 1 : m_g0;
                end
            end else if (m_resp) begin
                if (m_gid ? rsp1_ready : rsp0_ready) m_busy = 0;
            end else if (m_settle > 0) begin
                if (m_settle == 1) begin
                    m_resp = 1; m_err = 0; m_c = matmul(m_a, m_b);
                end
                m_settle--;
            end else if (m_age == 0) begin
                m_age = 1;
            end else if (mm_done) begin
                if (TB_CD == 0) begin
                    m_resp = 1; m_err = 0; m_c = matmul(m_a, m_b);
                end else begin
                    m_settle = TB_CD;
                end
            end else if (m_age == TB_TO) begin
                m_resp = 1; m_err = 1; m_c = '0;
                m_to = (m_to < 255) ? m_to + 1 : m_to;
            end else begin
                m_age++;
            end
        end
    end

    // Driver side: samples at the falling edge, drives just after the rising edge.
    int          cyc = 0, n_start = 0;
    logic        s_r0, s_r1, s_v0, s_v1, s_e0, s_e1;
    logic [31:0] s_c0, s_c1;

    task automatic step();
        @(negedge clk);
        s_r0 = req0_ready; s_r1 = req1_ready;
        s_v0 = rsp0_valid; s_v1 = rsp1_valid;
        s_c0 = rsp0_c; s_c1 = rsp1_c; s_e0 = rsp0_err; s_e1 = rsp1_err;
        if (mm_start) n_start++;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req0_valid = 0; req1_valid = 0;
        rst = 1;
        step();
        step();
        rst = 0;
    endtask

    task automatic send(input int id, input logic [31:0] a, input logic [31:0] b, output int acc_cyc);
        logic ok;
        ok = 0; acc_cyc = -1;
        if (id == 0) begin req0_valid = 1; req0_a = a; req0_b = b; end
        else         begin req1_valid = 1; req1_a = a; req1_b = b; end
        for (int i = 0; i < 60 && !ok; i++) begin
            step();
            if ((id == 0) ? s_r0 : s_r1) begin ok = 1; acc_cyc = cyc; end
        end
        if (id == 0) req0_valid = 0; else req1_valid = 0;
        chk1("accept_within_bound", ok, 1'b1);
    endtask

    task automatic wait_rsp(input int id, output int rcyc, output logic [31:0] c, output logic e);
        logic ok;
        ok = 0; rcyc = -1; c = '0; e = 1'b0;
        for (int i = 0; i < 80 && !ok; i++) begin
            step();
            if ((id == 0) ? s_v0 : s_v1) begin
                ok = 1; rcyc = cyc;
                c = (id == 0) ? s_c0 : s_c1;
                e = (id == 0) ? s_e0 : s_e1;
            end
        end
        chk1("response_within_bound", ok, 1'b1);
    endtask

    initial begin
        #(1_000_000);
        $display("FAIL watchdog: simulation did not finish by %0t", $time);
        $fatal(1, "watchdog");
    end

    int          ta, tr, rel, acc;
    int          g[4];
    int          gn;
    logic [31:0] c, ca, cb, hold_c;
    logic        e, a0, a1;

    initial begin
        #2 rst = 1;
        repeat (3) step();
        rst = 0;

        // Single request with the reference operands.
        mock_fixed = 2; n_start = 0;
        send(0, 32'h04030201, 32'h08070605, ta);
        wait_rsp(0, tr, c, e);
        chk_int("single_latency", tr - ta, 4);
        chk32("single_c", c, 32'h322b1613);
        chk1("single_err", e, 1'b0);
        repeat (3) step();
        chk_int("single_start_pulses", n_start, 1);

        // Both requesters held high from reset: grants alternate.
        do_reset();
        req0_valid = 1; req0_a = $urandom; req0_b = $urandom;
        req1_valid = 1; req1_a = $urandom; req1_b = $urandom;
        gn = 0;
        for (int i = 0; i < 200 && gn < 4; i++) begin
            step();
            if (s_r0 && req0_valid) begin g[gn] = 0; gn++; req0_a = $urandom; req0_b = $urandom; end
            else if (s_r1 && req1_valid) begin g[gn] = 1; gn++; req1_a = $urandom; req1_b = $urandom; end
        end
        req0_valid = 0; req1_valid = 0;
        chk_int("rr_grant_count", gn, 4);
        chk_int("rr_grant0", g[0], 0);
        chk_int("rr_grant1", g[1], 1);
        chk_int("rr_grant2", g[2], 0);
        chk_int("rr_grant3", g[3], 1);
        repeat (10) step();

        // Watchdog expiry, then normal service, then done colliding with the last WAIT cycle.
        mock_fixed = 0;
        send(1, $urandom, $urandom, ta);
        wait_rsp(1, tr, c, e);
        chk_int("timeout_latency", tr - ta, TB_TO + 2);
        chk32("timeout_c", c, 32'd0);
        chk1("timeout_err", e, 1'b1);
        mock_fixed = 2;
        ca = $urandom; cb = $urandom;
        send(0, ca, cb, ta);
        wait_rsp(0, tr, c, e);
        chk_int("after_timeout_latency", tr - ta, 4);
        chk32("after_timeout_c", c, matmul(ca, cb));
        chk1("after_timeout_err", e, 1'b0);
        mock_fixed = TB_TO;
        ca = $urandom; cb = $urandom;
        send(1, ca, cb, ta);
        wait_rsp(1, tr, c, e);
        chk_int("collide_latency", tr - ta, TB_TO + 2);
        chk32("collide_c", c, matmul(ca, cb));
        chk1("collide_err", e, 1'b0);

        // Response back-pressure while the other requester waits.
        mock_fixed = 2; rsp0_ready = 0;
        send(0, $urandom, $urandom, ta);
        req1_valid = 1; req1_a = $urandom; req1_b = $urandom;
        wait_rsp(0, tr, hold_c, e);
        for (int i = 0; i < 10; i++) begin
            step();
            chk1("hold_rsp0_valid", s_v0, 1'b1);
            chk32("hold_rsp0_c", s_c0, hold_c);
            chk1("hold_req1_ready", s_r1, 1'b0);
        end
        rsp0_ready = 1;
        step();
        rel = cyc;
        chk1("release_req1_ready", s_r1, 1'b0);
        acc = -1;
        for (int i = 0; i < 6 && acc < 0; i++) begin
            step();
            if (s_r1) acc = cyc;
        end
        req1_valid = 0;
        chk_int("accept_after_release", acc, rel + 1);
        wait_rsp(1, tr, c, e);

        // Asynchronous reset while waiting on the unit.
        mock_fixed = 0;
        send(0, $urandom, $urandom, ta);
        repeat (3) step();
        #1 rst = 1;
        #1;
        chk1("async_rst_busy", busy, 1'b0);
        chk1("async_rst_start", mm_start, 1'b0);
        chk32("async_rst_mm_a", mm_a, 32'd0);
        chk1("async_rst_rsp0_valid", rsp0_valid, 1'b0);
        step();
        step();
        rst = 0;
        mock_fixed = 2;
        req0_valid = 1; req0_a = $urandom; req0_b = $urandom;
        req1_valid = 1; req1_a = $urandom; req1_b = $urandom;
        step();
        chk1("post_rst_req0_wins", s_r0, 1'b1);
        chk1("post_rst_req1_waits", s_r1, 1'b0);
        req0_valid = 0; req1_valid = 0;
        wait_rsp(0, tr, c, e);
        ca = $urandom; cb = $urandom;
        send(1, ca, cb, ta);
        wait_rsp(1, tr, c, e);
        chk32("post_rst_req1_c", c, matmul(ca, cb));
        chk1("post_rst_req1_err", e, 1'b0);

        // Random traffic against the model.
        mock_fixed = -1;
        for (int i = 0; i < 2500; i++) begin
            step();
            a0 = req0_valid && s_r0;
            a1 = req1_valid && s_r1;
            if (a0) req0_valid = 0;
            if (a1) req1_valid = 0;
            if (!req0_valid && $urandom_range(0, 2) == 0) begin
                req0_valid = 1; req0_a = $urandom; req0_b = $urandom;
            end
            if (!req1_valid && $urandom_range(0, 2) == 0) begin
                req1_valid = 1; req1_a = $urandom; req1_b = $urandom;
            end
            rsp0_ready = ($urandom_range(0, 3) != 0);
            rsp1_ready = ($urandom_range(0, 3) != 0);
        end
        req0_valid = 0; req1_valid = 0; rsp0_ready = 1; rsp1_ready = 1;
        repeat (40) step();

`ifdef MATMUL_ARB_STATS_EN
        do_reset();
        mock_fixed = 2;
        for (int i = 0; i < 3; i++) begin
            send(0, $urandom, $urandom, ta);
            wait_rsp(0, tr, c, e);
        end
        mock_fixed = 0;
        send(1, $urandom, $urandom, ta);
        wait_rsp(1, tr, c, e);
        step();
        chk32("stats_grant0", 32'(stat_grant0), 32'd3);
        chk32("stats_grant1", 32'(stat_grant1), 32'd1);
        chk32("stats_timeout", 32'(stat_timeout), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
